gs_row_sequencer: RTL

// Parametrised grayscale shift sequencer for multiplexed LED-driver chains. It walks the

---
 rtl/gs_row_sequencer_pkg.sv | 20 ++
 rtl/gs_row_sequencer_if.sv | 39 +++
 rtl/gs_row_sequencer_plane_counter.sv | 55 +++++
 rtl/gs_row_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/gs_row_sequencer_pkg.sv
// Shared types and width helpers for the grayscale row sequencer.
package gs_seq_pkg;

   typedef enum logic [1:0] {INIT, SHIFT, BLANK, FINISH} seq_state_t;

   // Counter width for n distinct values, never below one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
   endfunction

   // load_row also encodes "no row" as NB_ROWS, hence the extra bit.
   function automatic int unsigned load_w(input int unsigned nb_rows);
      return 32'($clog2(nb_rows)) + 32'd1;
   endfunction

   function automatic int unsigned row_w(input int unsigned nb_rows, input int unsigned onehot);
      return (onehot != 0) ? nb_rows : cnt_w(nb_rows);
   endfunction

endpackage

// File: rtl/gs_row_sequencer_if.sv
// Bus between the sequencer and its angle/SCLK source and frame-memory addressing.
interface gs_row_sequencer_if #(
   parameter int unsigned NB_ANGLES         = 128,
   parameter int unsigned NB_LEDS_PER_GROUP = 16,
   parameter int unsigned NB_COLORS         = 3,
   parameter int unsigned GS_BITS           = 9,
   parameter int unsigned NB_ROWS           = 4,
   parameter int unsigned ROW_ONEHOT        = 1
);
   localparam int unsigned ANGLE_W = gs_seq_pkg::cnt_w(NB_ANGLES);
   localparam int unsigned COLOR_W = gs_seq_pkg::cnt_w(NB_COLORS);
   localparam int unsigned LED_W   = gs_seq_pkg::cnt_w(NB_LEDS_PER_GROUP);
   localparam int unsigned BS_W    = gs_seq_pkg::cnt_w(GS_BITS);
   localparam int unsigned LOAD_W  = gs_seq_pkg::load_w(NB_ROWS);
   localparam int unsigned ROW_W   = gs_seq_pkg::row_w(NB_ROWS, ROW_ONEHOT);

   logic               SCLK;
   logic [ANGLE_W-1:0] angle;
   logic               FC_en;
   logic [COLOR_W-1:0] color;
   logic [LED_W-1:0]   led;
   logic [BS_W-1:0]    bit_sel;
   logic [LOAD_W-1:0]  load_row;
   logic [ROW_W-1:0]   row_en;
   logic               row_valid;
   logic               LAT;
   logic               shifting;
   logic               frame_done;

   modport master (
      input  SCLK, angle, FC_en,
      output color, led, bit_sel, load_row, row_en, row_valid, LAT, shifting, frame_done
   );

   modport slave (
      output SCLK, angle, FC_en,
      input  color, led, bit_sel, load_row, row_en, row_valid, LAT, shifting, frame_done
   );
endinterface

// File: rtl/gs_row_sequencer_plane_counter.sv
// Color -> LED -> bit-plane cascade counter with combinational wrap flags.
module gs_plane_counter
   import gs_seq_pkg::*;
#(
   parameter int unsigned NB_LEDS_PER_GROUP = 16,
   parameter int unsigned NB_COLORS         = 3,
   parameter int unsigned GS_BITS           = 9
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_clr,
   input  logic                                 i_inc,
   output logic [cnt_w(NB_COLORS)-1:0]          o_color,
   output logic [cnt_w(NB_LEDS_PER_GROUP)-1:0]  o_led,
   output logic [cnt_w(GS_BITS)-1:0]            o_bit_sel,
   output logic                                 o_end_color_c,
   output logic                                 o_end_led_c,
   output logic                                 o_end_plane_c
);
   localparam int unsigned COLOR_W = cnt_w(NB_COLORS);
   localparam int unsigned LED_W   = cnt_w(NB_LEDS_PER_GROUP);
   localparam int unsigned BS_W    = cnt_w(GS_BITS);

   logic [COLOR_W-1:0] r_color;
   logic [LED_W-1:0]   r_led;
   logic [BS_W-1:0]    r_bit_sel;

   assign o_end_color_c = (r_color == '0);
   assign o_end_led_c   = o_end_color_c && (r_led == LED_W'(NB_LEDS_PER_GROUP - 1));
   assign o_end_plane_c = o_end_led_c && (r_bit_sel == '0);

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_color   <= COLOR_W'(NB_COLORS - 1);
         r_led     <= '0;
         r_bit_sel <= BS_W'(GS_BITS - 1);
      end else if (i_inc) begin
         if (!o_end_color_c) begin
            r_color <= r_color - COLOR_W'(1);
         end else begin
            r_color <= COLOR_W'(NB_COLORS - 1);
            if (!o_end_led_c) begin
               r_led <= r_led + LED_W'(1);
            end else begin
               r_led     <= '0;
               r_bit_sel <= o_end_plane_c ? BS_W'(GS_BITS - 1) : r_bit_sel - BS_W'(1);
            end
         end
      end
   end

   assign o_color   = r_color;
   assign o_led     = r_led;
   assign o_bit_sel = r_bit_sel;
endmodule

// File: rtl/gs_row_sequencer.sv
// Grayscale shift sequencer: walks plane counters on SCLK, decodes LAT and steps
// multiplexed row enables, restarting on every angle change or FC write.
module gs_row_sequencer
   import gs_seq_pkg::*;
#(
   parameter int unsigned NB_ANGLES         = 128,
   parameter int unsigned NB_LEDS_PER_GROUP = 16,
   parameter int unsigned NB_COLORS         = 3,
   parameter int unsigned GS_BITS           = 9,
   parameter int unsigned NB_ROWS           = 4,
   parameter int unsigned ROW_ONEHOT        = 1,
   parameter int unsigned WRTGS_LEN         = 1,
   parameter int unsigned LATGS_LEN         = 3,
   parameter int unsigned BLANK_SCLKS       = 2
) (
   input  logic               clk,
   input  logic               rst,
   gs_row_sequencer_if.master io_seq
);
   localparam int unsigned ANGLE_W  = cnt_w(NB_ANGLES);
   localparam int unsigned COLOR_W  = cnt_w(NB_COLORS);
   localparam int unsigned LED_W    = cnt_w(NB_LEDS_PER_GROUP);
   localparam int unsigned BS_W     = cnt_w(GS_BITS);
   localparam int unsigned LOAD_W   = load_w(NB_ROWS);
   localparam int unsigned ROW_W    = row_w(NB_ROWS, ROW_ONEHOT);
   localparam int unsigned WORD_LEN = NB_LEDS_PER_GROUP * NB_COLORS;
   localparam int unsigned POS_W    = cnt_w(WORD_LEN + 1);
   localparam int unsigned BLK_W    = cnt_w(BLANK_SCLKS + 1);
   localparam int unsigned BLK_LAST = (BLANK_SCLKS == 0) ? 0 : BLANK_SCLKS - 1;

   seq_state_t         r_state;
   logic               r_prev_sclk;
   logic [ANGLE_W-1:0] r_prev_angle;
   logic [LOAD_W-1:0]  r_load_row;
   logic [BLK_W-1:0]   r_blank_cnt;
   logic [ROW_W-1:0]   r_row_en;
   logic               r_row_valid;
   logic               r_frame_done;

   logic               w_sclk_rise;
   logic               w_restart;
   logic               w_active;
   logic               w_inc;
   logic               w_row_end;
   logic               w_lat;
   logic [COLOR_W-1:0] w_color;
   logic [LED_W-1:0]   w_led;
   logic [BS_W-1:0]    w_bit_sel;
   logic               w_end_color;
   logic               w_end_led;
   logic               w_end_plane;
   logic [POS_W-1:0]   w_pos;
   logic [ROW_W-1:0]   w_row_code;

   assign w_sclk_rise = io_seq.SCLK & ~r_prev_sclk;
   assign w_restart   = io_seq.FC_en | (io_seq.angle != r_prev_angle);
   assign w_active    = (r_state == INIT) || (r_state == SHIFT);
   assign w_inc       = w_sclk_rise & w_active & ~w_restart;
   assign w_row_end   = w_inc & w_end_color & w_end_led & w_end_plane;

   gs_plane_counter #(
      .NB_LEDS_PER_GROUP (NB_LEDS_PER_GROUP),
      .NB_COLORS         (NB_COLORS),
      .GS_BITS           (GS_BITS)
   ) u_plane_counter (
      .clk           (clk),
      .rst           (rst),
      .i_clr         (w_restart),
      .i_inc         (w_inc),
      .o_color       (w_color),
      .o_led         (w_led),
      .o_bit_sel     (w_bit_sel),
      .o_end_color_c (w_end_color),
      .o_end_led_c   (w_end_led),
      .o_end_plane_c (w_end_plane)
   );

   // Enable code for the row whose load just completed.
   always_comb begin
      w_row_code = '0;
      if (ROW_ONEHOT != 0) w_row_code = ROW_W'(1) << r_load_row;
      else                 w_row_code = ROW_W'(r_load_row);
   end

   assign w_pos = POS_W'(w_led) * POS_W'(NB_COLORS) + POS_W'(NB_COLORS - 1) - POS_W'(w_color);
   assign w_lat = w_active && ((w_bit_sel != '0) ? (w_pos >= POS_W'(WORD_LEN - WRTGS_LEN))
                                                 : (w_pos >= POS_W'(WORD_LEN - LATGS_LEN)));

   always_ff @(posedge clk) begin
      r_prev_sclk  <= io_seq.SCLK;
      r_prev_angle <= io_seq.angle;
      if (rst || w_restart) begin
         r_state      <= INIT;
         r_load_row   <= '0;
         r_blank_cnt  <= '0;
         r_row_en     <= '0;
         r_row_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            INIT, SHIFT: begin
               if (w_row_end) begin
                  if (r_load_row == LOAD_W'(NB_ROWS)) begin
                     // Display-only pass for the last row is over.
                     r_state      <= FINISH;
                     r_frame_done <= 1'b1;
                     r_row_en     <= '0;
                     r_row_valid  <= 1'b0;
                  end else if (BLANK_SCLKS == 0) begin
                     r_state     <= SHIFT;
                     r_row_en    <= w_row_code;
                     r_row_valid <= 1'b1;
                     r_load_row  <= r_load_row + LOAD_W'(1);
                  end else begin
                     r_state     <= BLANK;
                     r_blank_cnt <= '0;
                     r_row_en    <= '0;
                     r_row_valid <= 1'b0;
                  end
               end
            end
            BLANK: begin
               if (w_sclk_rise) begin
                  if (r_blank_cnt == BLK_W'(BLK_LAST)) begin
                     r_state     <= SHIFT;
                     r_row_en    <= w_row_code;
                     r_row_valid <= 1'b1;
                     r_load_row  <= r_load_row + LOAD_W'(1);
                  end else begin
                     r_blank_cnt <= r_blank_cnt + BLK_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign io_seq.color      = w_color;
   assign io_seq.led        = w_led;
   assign io_seq.bit_sel    = w_bit_sel;
   assign io_seq.load_row   = r_load_row;
   assign io_seq.row_en     = r_row_en;
   assign io_seq.row_valid  = r_row_valid;
   assign io_seq.LAT        = w_lat;
   assign io_seq.shifting   = w_active;
   assign io_seq.frame_done = r_frame_done;
endmodule
